mmio_console_tx: RTL and testbench

//  Memory-mapped console output; the transmit counterpart of the keyboard-input MMIO path.
//  CPU stores bytes to TX_ADDR; they are buffered in a FIFO.

---
 rtl/mmio_console_tx.sv | 71 +++++++
 tb/tb_mmio_console_tx.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mmio_console_tx.sv
// mmio_console_tx: MMIO console byte FIFO (store TX_ADDR, status {overflow,full,empty} at STAT_ADDR) draining to a valid/ready sink; rst active-low sync; CONSOLE_TX_CRLF_EN expands 0a into 0d,0a
module mmio_console_tx #(
  parameter int          FIFO_AW   = 4,
  parameter logic [31:0] TX_ADDR   = 32'hfbadbef0,
  parameter logic [31:0] STAT_ADDR = 32'hfbadbef4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        hit,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        overflow
);
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(1) << FIFO_AW;
  logic [7:0] mem_q [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic full, empty, tx_sel, st_sel, push, pop, xfer;
  logic [7:0] head;
  logic unused_ok;
  assign unused_ok = ^data_in[31:8];
  assign full = count_q == DEPTH;
  assign empty = count_q == '0;
  assign tx_sel = store && addr == TX_ADDR;
  assign st_sel = load && addr == STAT_ADDR;
  assign push = tx_sel && !full;
  assign head = mem_q[rd_ptr_q];
  assign tx_valid = !empty;
  assign xfer = tx_valid && tx_ready;
  assign overflow = overflow_q;
  assign hit = (load || store) && (addr == TX_ADDR || addr == STAT_ADDR);
  assign data_out = st_sel ? {29'b0, overflow_q, full, empty} : 32'b0;
`ifdef CONSOLE_TX_CRLF_EN
  logic cr_pending_q, cr_pending_d, is_nl;
  assign is_nl = head == 8'h0a;
  assign tx_data = is_nl && !cr_pending_q ? 8'h0d : head;
  assign pop = xfer && !(is_nl && !cr_pending_q);
  assign cr_pending_d = xfer && is_nl ? !cr_pending_q : cr_pending_q;
  always_ff @(posedge clk) cr_pending_q <= !rst ? 1'b0 : cr_pending_d;
`else
  assign tx_data = head;
  assign pop = xfer;
`endif
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    overflow_d = tx_sel && full ? 1'b1 : st_sel ? 1'b0 : overflow_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= data_in[7:0];
endmodule

// File: tb/tb_mmio_console_tx.sv
// tb_mmio_console_tx: directed self-checking bench for mmio_console_tx
module tb_mmio_console_tx;
  localparam logic [31:0] TXA = 32'hfbadbef0;
  localparam logic [31:0] STA = 32'hfbadbef4;
  logic clk = 0, rst = 0, load = 0, store = 0, tx_ready = 0;
  logic [31:0] addr = 0, data_in = 0;
  logic [31:0] data_out;
  logic hit, tx_valid, overflow;
  logic [7:0] tx_data;
  int total = 0, bad = 0;
  mmio_console_tx dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .addr(addr), .data_in(data_in),
    .data_out(data_out), .hit(hit), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [7:0] b);
    store = 1;
    addr = TXA;
    data_in = {24'habcdef, b};
    step;
    store = 0;
    addr = 0;
  endtask
  task automatic stat(input string tag, input logic [31:0] exp);
    load = 1;
    addr = STA;
    #1;
    chk(tag, data_out, exp);
    chk({tag, "_hit"}, 32'(hit), 32'd1);
    step;
    load = 0;
    addr = 0;
  endtask
  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) put(base + 8'(i));
  endtask
  task automatic drain(input string tag, input logic [7:0] base, input int n);
    tx_ready = 1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_data"}, 32'(tx_data), 32'(base + 8'(i)));
      step;
    end
    tx_ready = 0;
    #1;
    chk({tag, "_empty"}, 32'(tx_valid), 32'd0);
  endtask
  initial begin
    step;
    step;
    rst = 1;
    #1;
    chk("por_valid", 32'(tx_valid), 32'd0);
    chk("por_overflow", 32'(overflow), 32'd0);
    stat("por_stat", 32'h1);
    put(8'h55);
    put(8'h66);
    chk("pre_rst_valid", 32'(tx_valid), 32'd1);
    rst = 0;
    step;
    step;
    rst = 1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    stat("rst_stat", 32'h1);
    put(8'h41);
    chk("t2_valid", 32'(tx_valid), 32'd1);
    chk("t2_head", 32'(tx_data), 32'h41);
    put(8'h42);
    step;
    chk("t2_hold", 32'(tx_data), 32'h41);
    drain("t2", 8'h41, 2);
    fill(8'h00, 17);
    chk("t3_ovf_pin", 32'(overflow), 32'd1);
    stat("t3_stat_full", 32'h6);
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    drain("t3", 8'h00, 16);
    stat("t3_stat_after", 32'h1);
    fill(8'h20, 16);
    stat("t4_stat_full", 32'h2);
    tx_ready = 1;
    put(8'h99);
    tx_ready = 0;
    stat("t4_stat", 32'h4);
    drain("t4", 8'h21, 15);
    fill(8'h30, 16);
    drain("t5a", 8'h30, 16);
    fill(8'h50, 16);
    drain("t5b", 8'h50, 16);
    load = 1;
    addr = TXA;
    #1;
    chk("ld_tx_data", data_out, 32'h0);
    chk("ld_tx_hit", 32'(hit), 32'd1);
    addr = 32'h1000;
    #1;
    chk("ld_other_data", data_out, 32'h0);
    chk("ld_other_hit", 32'(hit), 32'd0);
    load = 0;
    store = 1;
    addr = STA;
    data_in = 32'h77;
    step;
    store = 0;
    chk("st_stat_ignored", 32'(tx_valid), 32'd0);
    load = 1;
    store = 1;
    addr = TXA;
    data_in = 32'h63;
    #1;
    chk("ldst_data", data_out, 32'h0);
    step;
    load = 0;
    store = 0;
    addr = 0;
    drain("ldst", 8'h63, 1);
    put(8'h0a);
    tx_ready = 1;
`ifdef CONSOLE_TX_CRLF_EN
    chk("t6_cr", 32'(tx_data), 32'h0d);
    step;
    chk("t6_lf_valid", 32'(tx_valid), 32'd1);
`endif
    chk("t6_lf", 32'(tx_data), 32'h0a);
    step;
    chk("t6_empty", 32'(tx_valid), 32'd0);
    tx_ready = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
